// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for the R2^2 SDF FFT pipeline: stage-0 sample counter, zero flush,
// frames-in-flight tracking and bit-reversed output bin qualification.
module fft_r22sdf_ctrl #(
    parameter int unsigned FFT_N     = 1024,
    parameter int unsigned FFT_NLOG2 = 10,
    parameter int unsigned LATENCY   = 1024,
    parameter int unsigned PEND_W    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 valid_i,
    output logic [FFT_NLOG2-1:0] cnt_o,
    output logic                 zero_o,
    output logic                 busy_o,
    output logic                 out_valid_o,
    output logic [FFT_NLOG2-1:0] out_idx_o,
    output logic                 out_last_o,
    output logic                 err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam int unsigned          LAT_W    = $clog2(LATENCY + 1);
    localparam logic [FFT_NLOG2-1:0] LAST_IDX = FFT_NLOG2'(FFT_N - 1);
    localparam logic [LAT_W-1:0]     LAT_HIT  = LAT_W'(LATENCY - 1);
    localparam logic [PEND_W-1:0]    PEND_MAX = '1;

    logic [1:0]           state, state_nxt;
    logic [FFT_NLOG2-1:0] cnt, ocnt;
    logic [PEND_W-1:0]    pend, pend_nxt;
    logic [LAT_W-1:0]     lat;
    logic                 lat_run, lat_hit;
    logic                 out_act, out_act_nxt;
    logic                 err;
    logic                 frame_start, abort, out_dec, pend_ovf;
    logic [1:0]           dec_n;

    // Frames are counted when their first sample enters, so the output side
    // always finds its frame already pending even when LATENCY < FFT_N;
    // an aborted partial frame is taken back out of the count.
    always_comb begin
        frame_start = valid_i && ((state == S_ARMED) ||
                                  (state == S_RUN && cnt == '0));
        abort       = (state == S_RUN) && !valid_i && (cnt != '0);
        out_dec     = out_act && (ocnt == LAST_IDX);
        lat_hit     = lat_run && (lat == LAT_HIT);
        dec_n       = {1'b0, abort} + {1'b0, out_dec};

        pend_nxt = pend;
        pend_ovf = 1'b0;
        if (frame_start) begin
            if (!out_dec) begin
                if (pend == PEND_MAX) begin
                    pend_ovf = 1'b1;
                end else begin
                    pend_nxt = pend + 1'b1;
                end
            end
        end else if (int'(pend) > int'(dec_n)) begin
            pend_nxt = pend - PEND_W'(dec_n);
        end else begin
            pend_nxt = '0;
        end

        if (out_act) begin
            out_act_nxt = !(out_dec && pend_nxt == '0);
        end else begin
            out_act_nxt = lat_hit && (pend_nxt != '0);
        end

        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_ARMED;
            S_ARMED: if (valid_i) state_nxt = S_RUN;
            S_RUN:   if (!valid_i) state_nxt = S_FLUSH;
            S_FLUSH: if (pend_nxt == '0 && !out_act_nxt) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ocnt    <= '0;
            pend    <= '0;
            lat     <= '0;
            lat_run <= 1'b0;
            out_act <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            out_act <= out_act_nxt;
            if (pend_ovf || abort) begin
                err <= 1'b1;
            end

            case (state)
                S_ARMED: cnt <= valid_i ? FFT_NLOG2'(1) : '0;
                S_RUN,
                S_FLUSH: cnt <= (state_nxt == S_IDLE) ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase

            ocnt <= (out_act && out_act_nxt) ? ocnt + 1'b1 : '0;

            if (state == S_IDLE) begin
                lat_run <= 1'b0;
                lat     <= '0;
            end else if (state == S_ARMED && valid_i) begin
                lat_run <= 1'b1;
                lat     <= LAT_W'(1);
            end else if (lat_run) begin
                if (lat_hit) begin
                    lat_run <= 1'b0;
                end else begin
                    lat <= lat + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_idx_o = '0;
        for (int unsigned i = 0; i < FFT_NLOG2; i++) begin
            out_idx_o[i] = ocnt[FFT_NLOG2-1-i];
        end
    end

    assign cnt_o       = cnt;
    assign zero_o      = (state == S_FLUSH) || (state == S_RUN && !valid_i);
    assign busy_o      = (state != S_IDLE);
    assign out_valid_o = out_act;
    assign out_last_o  = out_dec;
    assign err_o       = err;

endmodule
